// File: rtl/vga_timing.sv
// 640x480@60 raster generator: combinational 1-based x/y/video_active from the counters; blanked rgb,
// syncs and frame_start registered one cycle behind x/y. There is no backpressure: the raster free-runs.
module vga_timing #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        CLOCK_25,
    input  logic        RESET,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        video_active,
    output logic [2:0]  vga_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int   H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic SYNC_ON  = !SYNC_ACTIVE_LOW;
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        h_sync_win, v_sync_win;

    assign video_active = (h_cnt_q < 12'(H_VISIBLE)) && (v_cnt_q < 12'(V_VISIBLE));
    assign x            = video_active ? h_cnt_q + 12'd1 : 12'd0;
    assign y            = video_active ? v_cnt_q + 12'd1 : 12'd0;

    assign h_sync_win = (h_cnt_q >= 12'(H_VISIBLE + H_FRONT)) &&
                        (h_cnt_q <= 12'(H_VISIBLE + H_FRONT + H_SYNC - 1));
    assign v_sync_win = (v_cnt_q >= 12'(V_VISIBLE + V_FRONT)) &&
                        (v_cnt_q <= 12'(V_VISIBLE + V_FRONT + V_SYNC - 1));

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == 12'(H_TOTAL - 1)) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == 12'(V_TOTAL - 1)) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    // Pin-side values are computed from the current counters, so they land one cycle after x/y.
    always_comb begin
        rgb_d         = video_active ? color : 3'b000;
        hsync_d       = h_sync_win ? SYNC_ON : SYNC_OFF;
        vsync_d       = v_sync_win ? SYNC_ON : SYNC_OFF;
        frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end

    always_ff @(posedge CLOCK_25) begin
        if (RESET) begin
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            rgb_q         <= 3'b000;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_rgb     = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (full 640x480 timing, short-frame active-low, short-frame active-high)
// checked every cycle against a cycle-count raster model, plus literal timing points.
module tb_vga_timing;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int V_VIS [3] = '{480, 6, 6};
    localparam int V_FP  [3] = '{10, 2, 2};
    localparam int V_SY  [3] = '{2, 2, 2};
    localparam int V_BP  [3] = '{33, 3, 3};
    localparam bit SAL   [3] = '{1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  color;
    logic [11:0] x_w [3];
    logic [11:0] y_w [3];
    logic        va_w [3];
    logic [2:0]  rgb_w [3];
    logic        hs_w [3];
    logic        vs_w [3];
    logic        fs_w [3];

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vga_timing #(
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_VISIBLE(V_VIS[g]), .V_FRONT(V_FP[g]), .V_SYNC(V_SY[g]), .V_BACK(V_BP[g]),
            .SYNC_ACTIVE_LOW(SAL[g])
        ) u_dut (
            .CLOCK_25(clk), .RESET(rst), .color(color),
            .x(x_w[g]), .y(y_w[g]), .video_active(va_w[g]),
            .vga_rgb(rgb_w[g]), .hsync(hs_w[g]), .vsync(vs_w[g]), .frame_start(fs_w[g])
        );
    end

    task automatic chk(input string nm, input int c, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, c, $time, act, exp);
        end
    endtask

    function automatic logic lvl(input int c, input bit on);
        return SAL[c] ? !on : on;
    endfunction

    function automatic int vtot(input int c);
        return V_VIS[c] + V_FP[c] + V_SY[c] + V_BP[c];
    endfunction

    // Model: raster position is just the count of non-reset edges since the last reset, mod frame.
    longint     k [3];
    logic [2:0] e_rgb [3];
    logic       e_hs [3], e_vs [3], e_fs [3];
    bit         armed = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                k[c]     = 0;
                e_rgb[c] = 3'b000;
                e_hs[c]  = lvl(c, 1'b0);
                e_vs[c]  = lvl(c, 1'b0);
                e_fs[c]  = 1'b0;
            end else begin
                longint h, v;
                h = k[c] % HT;
                v = (k[c] / HT) % vtot(c);
                e_rgb[c] = (h < HV && v < V_VIS[c]) ? color : 3'b000;
                e_hs[c]  = lvl(c, h >= HV + HF && h < HV + HF + HS);
                e_vs[c]  = lvl(c, v >= V_VIS[c] + V_FP[c] && v < V_VIS[c] + V_FP[c] + V_SY[c]);
                e_fs[c]  = (h == 0 && v == 0);
                k[c]++;
            end
        end
        if (rst) armed = 1'b1;
        #1;
        if (armed) begin
            for (int c = 0; c < 3; c++) begin
                longint h, v;
                bit vis;
                h   = k[c] % HT;
                v   = (k[c] / HT) % vtot(c);
                vis = (h < HV && v < V_VIS[c]);
                chk("x", c, x_w[c], vis ? h + 1 : 0);
                chk("y", c, y_w[c], vis ? v + 1 : 0);
                chk("video_active", c, va_w[c], vis);
                chk("vga_rgb", c, rgb_w[c], e_rgb[c]);
                chk("hsync", c, hs_w[c], e_hs[c]);
                chk("vsync", c, vs_w[c], e_vs[c]);
                chk("frame_start", c, fs_w[c], e_fs[c]);
            end
        end
    end

    int hs_start = -1, hs_len = 0, vs_start = -1, vs_len = 0;
    int fs_times[$];

    initial begin
        rst   = 1'b1;
        color = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("lit_release_x", 0, x_w[0], 1);
        chk("lit_release_y", 0, y_w[0], 1);
        chk("lit_release_va", 0, va_w[0], 1);
        chk("lit_reset_hs_high", 2, hs_w[2], 0);
        color = 3'($urandom_range(0, 7));

        // i = number of non-reset edges seen so far
        for (int i = 1; i <= 22000; i++) begin
            @(negedge clk);
            if (i == 639) chk("lit_x_639", 0, x_w[0], 640);
            if (i == 640) begin
                chk("lit_x_blank", 0, x_w[0], 0);
                chk("lit_va_blank", 0, va_w[0], 0);
                chk("lit_rgb_last_vis", 0, rgb_w[0], 3'b101);
            end
            if (i == 641) chk("lit_rgb_first_blank", 0, rgb_w[0], 0);
            if (i == 799) chk("lit_x_799", 0, x_w[0], 0);
            if (i == 800) begin
                chk("lit_x_wrap", 0, x_w[0], 1);
                chk("lit_y_wrap", 0, y_w[0], 2);
            end
            if (i == 100) chk("lit_hs_high_idle", 2, hs_w[2], 0);
            if (i == 700) chk("lit_hs_high_pulse", 2, hs_w[2], 1);
            if (hs_w[0] == 1'b0 && i < 800) begin
                if (hs_start < 0) hs_start = i;
                hs_len++;
            end
            if (vs_w[1] == 1'b0 && i < 10400) begin
                if (vs_start < 0) vs_start = i;
                vs_len++;
            end
            if (fs_w[1]) fs_times.push_back(i);
            color = (i >= 600 && i < 700) ? 3'b101 : 3'($urandom_range(0, 7));
        end
        chk("lit_hsync_start", 0, hs_start, 657);
        chk("lit_hsync_len", 0, hs_len, 96);
        chk("lit_vsync_start", 1, vs_start, 6401);
        chk("lit_vsync_len", 1, vs_len, 1600);
        chk("lit_fs_count", 1, fs_times.size(), 3);
        if (fs_times.size() == 3) begin
            chk("lit_fs_first", 1, fs_times[0], 1);
            chk("lit_fs_period_a", 1, fs_times[1] - fs_times[0], 10400);
            chk("lit_fs_period_b", 1, fs_times[2] - fs_times[1], 10400);
        end

        rst   = 1'b1;
        color = 3'b111;
        repeat (3) begin
            @(negedge clk);
            chk("lit_rst_rgb", 0, rgb_w[0], 0);
            chk("lit_rst_hs", 0, hs_w[0], 1);
            chk("lit_rst_vs", 1, vs_w[1], 1);
            chk("lit_rst_fs", 1, fs_w[1], 0);
            chk("lit_rst_hs_high", 2, hs_w[2], 0);
        end
        rst = 1'b0;
        chk("lit_rerelease_x", 0, x_w[0], 1);
        chk("lit_rerelease_y", 0, y_w[0], 1);
        chk("lit_rerelease_va", 0, va_w[0], 1);

        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            color = 3'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
